// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one digit adder swept LSD first, one digit per clock.
// Ports: clk, rst (async high), start/cin/a/b in; busy, done, sum, cout, err out. Option: BCD_INPUT_CHECK_EN.

module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    if (s > 5'd15 || s[3:0] > 4'd9) begin
      sum  = s[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = s[3:0];
      cout = 1'b0;
    end
  end
endmodule

module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4,
  parameter int CW     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cin,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);
  localparam int W = 4 * DIGITS;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  a_sh, b_sh, sum_q, sum_shift;
  logic [CW-1:0] idx;
  logic          carry_reg, cout_q;
  logic [3:0]    dsum;
  logic          dcout;
  logic          accept;

  assign accept = (state == IDLE) && start;

  bcd_digit_add u_digit (
    .a    (a_sh[3:0]),
    .b    (b_sh[3:0]),
    .cin  (carry_reg),
    .sum  (dsum),
    .cout (dcout)
  );

  // Result digits enter at the MS end so digit 0 ends up at [3:0].
  generate
    if (DIGITS == 1) begin : g_one
      assign sum_shift = dsum;
    end else begin : g_many
      assign sum_shift = {dsum, sum_q[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum_q     <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_q    <= 1'b0;
    end else if (accept) begin
      a_sh      <= a;
      b_sh      <= b;
      sum_q     <= '0;
      idx       <= '0;
      carry_reg <= cin;
      cout_q    <= 1'b0;
    end else if (state == RUN) begin
      a_sh      <= a_sh >> 4;
      b_sh      <= b_sh >> 4;
      sum_q     <= sum_shift;
      idx       <= idx + CW'(1);
      carry_reg <= dcout;
      if (idx == LAST) cout_q <= dcout;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef BCD_INPUT_CHECK_EN
  logic err_q;

  // Sticky across the whole operand; only a new accepted start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= 1'b0;
    else if (state == RUN && (a_sh[3:0] > 4'd9 || b_sh[3:0] > 4'd9))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4).
// Vector table for sums plus hand sequences for latency, back-to-back, reset and hold.

module tb_bcd_serial_add_ctrl;
  localparam int DIGITS = 4;
  localparam int CW     = 3;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef BCD_INPUT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eerr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", {31'b0, busy}, 32'd0);
  endtask

  // Returns edges from the accepting edge to the first cycle with done high.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic tc, output int lat);
    wait_idle();
    a = ta; b = tb2; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  vec_t vecs[9];
  int   lat;
  int   ndone;
  int   last_e;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h0876, 16'h0145, 1'b1, 16'h1022, 1'b0, 1'b0};
    vecs[7] = '{16'h12A4, 16'h0000, 1'b0, 16'h1304, 1'b0, ERR_EXP};
    vecs[8] = '{16'h1234, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b0};

    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum",  {16'b0, sum},  32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_err",  {31'b0, err},  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, lat);
      check($sformatf("v%0d_latency", i), lat, DIGITS);
      check($sformatf("v%0d_sum", i), {16'b0, sum}, {16'b0, vecs[i].esum});
      check($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].ecout});
      check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].eerr});
      check($sformatf("v%0d_busy_done", i), {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // Start held high; operands are scrambled while busy and must not leak in.
    wait_idle();
    ndone = 0;
    last_e = -1;
    for (int e = 1; e <= 24; e++) begin
      start = 1'b1;
      a = busy ? 16'h9999 : 16'h0001;
      b = busy ? 16'h8888 : 16'h0002;
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        check("b2b_sum", {16'b0, sum}, 32'h0003);
        if (last_e >= 0) check("b2b_period", e - last_e, DIGITS + 2);
        last_e = e;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_count", ndone, 4);

    // Reset in the middle of RUN, after two digits have been consumed.
    wait_idle();
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_sum",  {16'b0, sum},  32'd0);
    check("arst_cout", {31'b0, cout}, 32'd0);
    check("arst_err",  {31'b0, err},  32'd0);
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("arst_no_done", ndone, 0);
    run_op(16'h0005, 16'h0005, 1'b0, lat);
    check("post_rst_sum",  {16'b0, sum},  32'h0010);
    check("post_rst_cout", {31'b0, cout}, 32'd0);

    // Result must hold while idle.
    run_op(16'h0042, 16'h0058, 1'b0, lat);
    check("hold_first", {16'b0, sum}, 32'h0100);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("hold_sum_%0d", k), {16'b0, sum}, 32'h0100);
      check($sformatf("hold_cout_%0d", k), {31'b0, cout}, 32'd0);
      check($sformatf("hold_done_%0d", k), {31'b0, done}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
